// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage register.
// Holds the occupancy state encoding and the control-bit index names.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int DATA_W_DEF   = 16;
    localparam int RD_W_DEF     = 4;
    localparam int CTRL_W_DEF   = 2;
    localparam int CNT_W_DEF    = 16;

    localparam int CTRL_MEM2REG = 0;
    localparam int CTRL_PCWRITE = 1;

    function automatic logic [1:0] state_occupancy(input pipe_state_e st);
        logic [1:0] occ;
        occ = 2'd0;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_FULL:  occ = 2'd1;
            ST_SKID:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage: a valid bit plus payload.
// Clear drops only the valid bit; the payload is kept until the next load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_memout,
    input  logic [DATA_W-1:0] in_aluout,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [RD_W-1:0]   rd,
    output logic [DATA_W-1:0] memout,
    output logic [DATA_W-1:0] aluout,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q, valid_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] memout_q, memout_d;
    logic [DATA_W-1:0] aluout_q, aluout_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Next slot contents: clear wins over load.
    always_comb begin
        valid_d  = valid_q;
        rd_d     = rd_q;
        memout_d = memout_q;
        aluout_d = aluout_q;
        ctrl_d   = ctrl_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d  = 1'b1;
            rd_d     = in_rd;
            memout_d = in_memout;
            aluout_d = in_aluout;
            ctrl_d   = in_ctrl;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers with asynchronous reset to all zeros.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rd_q     <= '0;
            memout_q <= '0;
            aluout_q <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_q     <= rd_d;
            memout_q <= memout_d;
            aluout_q <= aluout_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign valid  = valid_q;
    assign rd     = rd_q;
    assign memout = memout_q;
    assign aluout = aluout_q;
    assign ctrl   = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready stage register with a two-entry skid buffer, flush and bubble masking.
// Optional stall/bubble statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_memout,
    input  logic [DATA_W-1:0] in_aluout,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_memout,
    output logic [DATA_W-1:0] out_aluout,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  bubble_cycles
`endif
);

    pipe_state_e state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic [1:0]  occ_q, occ_d;

    logic accept_s, take_s;
    logic main_load_s, main_clear_s, main_sel_skid_s;
    logic skid_load_s, skid_clear_s;

    logic              main_valid_s, skid_valid_s;
    logic [RD_W-1:0]   main_rd_s, skid_rd_s, main_in_rd_s;
    logic [DATA_W-1:0] main_memout_s, skid_memout_s, main_in_memout_s;
    logic [DATA_W-1:0] main_aluout_s, skid_aluout_s, main_in_aluout_s;
    logic [CTRL_W-1:0] main_ctrl_s, skid_ctrl_s, main_in_ctrl_s;

    assign accept_s = in_valid & in_ready_q;
    assign take_s   = main_valid_s & out_ready;

    // Next state and slot control; flush overrides any transfer.
    always_comb begin
        state_d         = state_q;
        main_load_s     = 1'b0;
        main_clear_s    = 1'b0;
        main_sel_skid_s = 1'b0;
        skid_load_s     = 1'b0;
        skid_clear_s    = 1'b0;
        if (flush) begin
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
            state_d      = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_load_s = 1'b1;
                        state_d     = ST_FULL;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s && take_s) begin
                        main_load_s = 1'b1;
                        state_d     = ST_FULL;
                    end else if (accept_s) begin
                        skid_load_s = 1'b1;
                        state_d     = ST_SKID;
                    end else if (take_s) begin
                        main_clear_s = 1'b1;
                        state_d      = ST_EMPTY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (take_s) begin
                        main_load_s     = 1'b1;
                        main_sel_skid_s = 1'b1;
                        skid_clear_s    = 1'b1;
                        state_d         = ST_FULL;
                    end else begin
                        state_d = ST_SKID;
                    end
                end
                default: begin
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                    state_d      = ST_EMPTY;
                end
            endcase
        end
    end

    // Main slot refills from the skid slot when draining, otherwise from upstream.
    always_comb begin
        main_in_rd_s     = in_rd;
        main_in_memout_s = in_memout;
        main_in_aluout_s = in_aluout;
        main_in_ctrl_s   = in_ctrl;
        if (main_sel_skid_s) begin
            main_in_rd_s     = skid_rd_s;
            main_in_memout_s = skid_memout_s;
            main_in_aluout_s = skid_aluout_s;
            main_in_ctrl_s   = skid_ctrl_s;
        end else begin
            main_in_rd_s = in_rd;
        end
    end

    // Registered ready and occupancy follow the next state.
    always_comb begin
        in_ready_d = (state_d != ST_SKID);
        occ_d      = state_occupancy(state_d);
    end

    // State, ready and occupancy registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            occ_q      <= occ_d;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_main (
        .clock     (clock),
        .rst       (rst),
        .load      (main_load_s),
        .clear     (main_clear_s),
        .in_rd     (main_in_rd_s),
        .in_memout (main_in_memout_s),
        .in_aluout (main_in_aluout_s),
        .in_ctrl   (main_in_ctrl_s),
        .valid     (main_valid_s),
        .rd        (main_rd_s),
        .memout    (main_memout_s),
        .aluout    (main_aluout_s),
        .ctrl      (main_ctrl_s)
    );

    pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_skid (
        .clock     (clock),
        .rst       (rst),
        .load      (skid_load_s),
        .clear     (skid_clear_s),
        .in_rd     (in_rd),
        .in_memout (in_memout),
        .in_aluout (in_aluout),
        .in_ctrl   (in_ctrl),
        .valid     (skid_valid_s),
        .rd        (skid_rd_s),
        .memout    (skid_memout_s),
        .aluout    (skid_aluout_s),
        .ctrl      (skid_ctrl_s)
    );

    assign in_ready   = in_ready_q;
    assign occupancy  = occ_q;
    assign out_valid  = main_valid_s;
    assign out_rd     = main_rd_s;
    assign out_memout = main_memout_s;
    assign out_aluout = main_aluout_s;
    // A bubble must never present mem2reg or pcwrite downstream.
    assign out_ctrl   = main_ctrl_s & {CTRL_W{main_valid_s}};

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    // Saturating stall and bubble counters; flush does not clear them.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (main_valid_s && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
        if (!main_valid_s && !flush && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end else begin
            bubble_d = bubble_q;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg, plus hand-written reset and statistics sequences.
// Statistics checks are compiled only when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_reg;

    logic        clock;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd;
    logic [15:0] in_memout;
    logic [15:0] in_aluout;
    logic [1:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_rd;
    logic [15:0] out_memout;
    logic [15:0] out_aluout;
    logic [1:0]  out_ctrl;
    logic [1:0]  occupancy;

    int n_tests;
    int n_fail;

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cycles, bubble_cycles;
    logic        s2_in_ready, s2_out_valid;
    logic [3:0]  s2_out_rd;
    logic [15:0] s2_out_memout, s2_out_aluout;
    logic [1:0]  s2_out_ctrl, s2_occupancy, s2_stall, s2_bubble;
`endif

    pipe_stage_reg dut (
        .clock      (clock),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_memout  (in_memout),
        .in_aluout  (in_aluout),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_memout (out_memout),
        .out_aluout (out_aluout),
        .out_ctrl   (out_ctrl),
        .occupancy  (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_reg #(.CNT_W(2)) dut_sat (
        .clock         (clock),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (s2_in_ready),
        .in_rd         (in_rd),
        .in_memout     (in_memout),
        .in_aluout     (in_aluout),
        .in_ctrl       (in_ctrl),
        .out_valid     (s2_out_valid),
        .out_ready     (out_ready),
        .out_rd        (s2_out_rd),
        .out_memout    (s2_out_memout),
        .out_aluout    (s2_out_aluout),
        .out_ctrl      (s2_out_ctrl),
        .occupancy     (s2_occupancy),
        .stall_cycles  (s2_stall),
        .bubble_cycles (s2_bubble)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [3:0]  rd;
        logic [15:0] mem;
        logic [15:0] alu;
        logic [1:0]  ctrl;
        logic        e_valid;
        logic        e_ready;
        logic [1:0]  e_occ;
        logic [3:0]  e_rd;
        logic [15:0] e_mem;
        logic [15:0] e_alu;
        logic [1:0]  e_ctrl;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
                                input logic [3:0] rd, input logic [15:0] mem,
                                input logic [15:0] alu, input logic [1:0] ctrl,
                                input logic ev, input logic er, input logic [1:0] eo,
                                input logic [3:0] erd, input logic [15:0] emem,
                                input logic [15:0] ealu, input logic [1:0] ectrl);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.out_ready = ordy;
        v.rd = rd; v.mem = mem; v.alu = alu; v.ctrl = ctrl;
        v.e_valid = ev; v.e_ready = er; v.e_occ = eo;
        v.e_rd = erd; v.e_mem = emem; v.e_alu = ealu; v.e_ctrl = ectrl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy,
                         input logic [3:0] rd, input logic [15:0] mem,
                         input logic [15:0] alu, input logic [1:0] ctrl);
        flush = fl; in_valid = iv; out_ready = ordy;
        in_rd = rd; in_memout = mem; in_aluout = alu; in_ctrl = ctrl;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 2'b00);

        //                fl    iv    or    rd    mem        alu        ctrl     ev    er    occ   erd   emem       ealu       ectrl
        vecs[0]  = mk(1'b0, 1'b1, 1'b1, 4'h1, 16'h1001, 16'h0010, 2'b01, 1'b1, 1'b1, 2'd1, 4'h1, 16'h1001, 16'h0010, 2'b01);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 4'h2, 16'h1002, 16'h0020, 2'b01, 1'b1, 1'b1, 2'd1, 4'h2, 16'h1002, 16'h0020, 2'b01);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 4'h3, 16'h1003, 16'h0030, 2'b01, 1'b1, 1'b1, 2'd1, 4'h3, 16'h1003, 16'h0030, 2'b01);
        vecs[3]  = mk(1'b0, 1'b1, 1'b1, 4'h4, 16'h1004, 16'h0040, 2'b01, 1'b1, 1'b1, 2'd1, 4'h4, 16'h1004, 16'h0040, 2'b01);
        vecs[4]  = mk(1'b0, 1'b1, 1'b1, 4'h5, 16'h1005, 16'h0050, 2'b01, 1'b1, 1'b1, 2'd1, 4'h5, 16'h1005, 16'h0050, 2'b01);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd0, 4'h5, 16'h1005, 16'h0050, 2'b00);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 4'h3, 16'h3333, 16'h0033, 2'b10, 1'b1, 1'b1, 2'd1, 4'h3, 16'h3333, 16'h0033, 2'b10);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 4'h7, 16'h7777, 16'h0077, 2'b01, 1'b1, 1'b0, 2'd2, 4'h3, 16'h3333, 16'h0033, 2'b10);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 4'h8, 16'h8888, 16'h0088, 2'b11, 1'b1, 1'b0, 2'd2, 4'h3, 16'h3333, 16'h0033, 2'b10);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b1, 2'd1, 4'h7, 16'h7777, 16'h0077, 2'b01);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd0, 4'h7, 16'h7777, 16'h0077, 2'b00);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 4'hA, 16'hAAAA, 16'h00AA, 2'b11, 1'b1, 1'b1, 2'd1, 4'hA, 16'hAAAA, 16'h00AA, 2'b11);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 4'hB, 16'hBBBB, 16'h00BB, 2'b00, 1'b1, 1'b0, 2'd2, 4'hA, 16'hAAAA, 16'h00AA, 2'b11);
        vecs[13] = mk(1'b1, 1'b1, 1'b1, 4'h9, 16'h9999, 16'h0099, 2'b11, 1'b0, 1'b1, 2'd0, 4'hA, 16'hAAAA, 16'h00AA, 2'b00);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd0, 4'hA, 16'hAAAA, 16'h00AA, 2'b00);
        vecs[15] = mk(1'b0, 1'b1, 1'b1, 4'h5, 16'h5555, 16'h0055, 2'b11, 1'b1, 1'b1, 2'd1, 4'h5, 16'h5555, 16'h0055, 2'b11);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd0, 4'h5, 16'h5555, 16'h0055, 2'b00);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd0, 4'h5, 16'h5555, 16'h0055, 2'b00);
        vecs[18] = mk(1'b0, 1'b1, 1'b1, 4'hC, 16'hCCCC, 16'h00CC, 2'b11, 1'b1, 1'b1, 2'd1, 4'hC, 16'hCCCC, 16'h00CC, 2'b11);
        vecs[19] = mk(1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd0, 4'hC, 16'hCCCC, 16'h00CC, 2'b00);

        #1 rst = 1'b1;
        #2;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.occupancy", 32'(occupancy), 32'd0);
        check("reset.out_rd", 32'(out_rd), 32'd0);
        check("reset.out_memout", 32'(out_memout), 32'd0);
        check("reset.out_aluout", 32'(out_aluout), 32'd0);
        check("reset.out_ctrl", 32'(out_ctrl), 32'd0);
        @(negedge clock);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready,
                  vecs[i].rd, vecs[i].mem, vecs[i].alu, vecs[i].ctrl);
            step();
            check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d.occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            check($sformatf("v%0d.out_rd", i), 32'(out_rd), 32'(vecs[i].e_rd));
            check($sformatf("v%0d.out_memout", i), 32'(out_memout), 32'(vecs[i].e_mem));
            check($sformatf("v%0d.out_aluout", i), 32'(out_aluout), 32'(vecs[i].e_alu));
            check($sformatf("v%0d.out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].e_ctrl));
        end

        // Fill both slots, then reset asynchronously between clock edges.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 4'h1, 16'h1111, 16'h0011, 2'b11);
        step();
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 4'h2, 16'h2222, 16'h0022, 2'b11);
        step();
        check("rstmid.pre_occupancy", 32'(occupancy), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rstmid.out_valid", 32'(out_valid), 32'd0);
        check("rstmid.out_ctrl", 32'(out_ctrl), 32'd0);
        check("rstmid.occupancy", 32'(occupancy), 32'd0);
        check("rstmid.out_rd", 32'(out_rd), 32'd0);
        @(negedge clock);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 2'b00);
        step();
        check("rstmid.post_in_ready", 32'(in_ready), 32'd1);
        check("rstmid.post_out_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_STAGE_STATS_EN
        // Load one entry straight out of reset: the load edge itself is a bubble.
        @(negedge clock);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 4'h6, 16'h6666, 16'h0066, 2'b01);
        @(negedge clock);
        rst = 1'b0;
        step();
        check("stats.load_bubble", 32'(bubble_cycles), 32'd1);
        check("stats.load_stall", 32'(stall_cycles), 32'd0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 2'b00);
        repeat (4) step();
        check("stats.stall4", 32'(stall_cycles), 32'd4);
        check("stats.stall4_bubble", 32'(bubble_cycles), 32'd1);
        check("stats.sat_stall4", 32'(s2_stall), 32'd3);
        @(negedge clock);
        out_ready = 1'b1;
        step();
        repeat (3) step();
        check("stats.idle3_bubble", 32'(bubble_cycles), 32'd4);
        check("stats.idle3_stall", 32'(stall_cycles), 32'd4);
        check("stats.sat_bubble", 32'(s2_bubble), 32'd3);
        @(negedge clock);
        flush = 1'b1;
        step();
        check("stats.flush_bubble", 32'(bubble_cycles), 32'd4);
        check("stats.flush_stall", 32'(stall_cycles), 32'd4);
        @(negedge clock);
        flush = 1'b0;
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 4'h6, 16'h6666, 16'h0066, 2'b01);
        @(negedge clock);
        rst = 1'b0;
        step();
        @(negedge clock);
        in_valid = 1'b0;
        repeat (6) step();
        check("stats.stall6", 32'(stall_cycles), 32'd6);
        check("stats.sat_stall6", 32'(s2_stall), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
